// File: rtl/systolic_feeder_if.sv
// Load/stream bus between the operand feeder and its controller.
interface systolic_feeder_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                  wr_en;
    logic                  wr_sel;
    logic [IDX_W-1:0]      wr_row;
    logic [IDX_W-1:0]      wr_col;
    logic [DATA_W-1:0]     wr_data;
    logic                  start;
    logic [N*DATA_W-1:0]   a_out;
    logic [N*DATA_W-1:0]   b_out;
    logic                  valid_out;
    logic                  busy;
    logic                  done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  a_out, b_out, valid_out, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output a_out, b_out, valid_out, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: stores A and B, then drives
// skewed, zero-padded west (A rows) and north (B columns) edge streams.
module systolic_feeder #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    systolic_feeder_if.slave  bus
);
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned T_LAST = 3 * N - 3;
    localparam int unsigned CNT_W  = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N*DATA_W-1:0] a_q, a_d;
    logic [N*DATA_W-1:0] b_q, b_d;

    logic [DATA_W-1:0]   mat_a [N][N];
    logic [DATA_W-1:0]   mat_b [N][N];

    logic                wr_ok;
    int                  d;

    // Loads are only accepted while idle; streaming contents stay frozen.
    assign wr_ok = bus.wr_en && (state_q == IDLE);

    // Matrix storage, cleared on reset and persistent across runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mat_a[r][c] <= '0;
                    mat_b[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (!bus.wr_sel) begin
                mat_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end else begin
                mat_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end
        end
    end

    // State, stream counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state plus next-cycle control outputs; t_d is the index presented next.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                    t_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            STREAM: begin
                busy_d = 1'b1;
                if (t_q == CNT_W'(T_LAST)) begin
                    state_d = DONE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d     = t_q + CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Skewed lane select; a write landing on the start edge is forwarded so
    // the very first stream cycle already sees it.
    always_comb begin
        a_d = '0;
        b_d = '0;
        d   = 0;
        if (valid_d) begin
            for (int i = 0; i < int'(N); i++) begin
                d = int'(t_d) - i;
                if (d >= 0 && d < int'(N)) begin
                    a_d[i*DATA_W +: DATA_W] = mat_a[IDX_W'(i)][IDX_W'(d)];
                    b_d[i*DATA_W +: DATA_W] = mat_b[IDX_W'(d)][IDX_W'(i)];
                    if (wr_ok && !bus.wr_sel &&
                        bus.wr_row == IDX_W'(i) && bus.wr_col == IDX_W'(d)) begin
                        a_d[i*DATA_W +: DATA_W] = bus.wr_data;
                    end
                    if (wr_ok && bus.wr_sel &&
                        bus.wr_row == IDX_W'(d) && bus.wr_col == IDX_W'(i)) begin
                        b_d[i*DATA_W +: DATA_W] = bus.wr_data;
                    end
                end
            end
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a scoreboard of expected frames
// and a small behavioural systolic array fed from the DUT outputs.
module tb_systolic_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NT = 3 * N - 2;

    logic clk;
    logic reset;
    logic arr_clr;

    systolic_feeder_if #(.N(N), .DATA_W(DW)) bus ();

    systolic_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [DW-1:0]     ma [N][N];
    logic [DW-1:0]     mb [N][N];
    logic [N*DW-1:0]   q_a [$];
    logic [N*DW-1:0]   q_b [$];
    logic [N*DW-1:0]   obs_a [NT];
    logic [N*DW-1:0]   obs_b [NT];

    // Behavioural array: A flows east, B flows south, every PE accumulates.
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [DW-1:0] ain [N][N];
    logic [DW-1:0] bin [N][N];
    logic [31:0]   acc [N][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_w
                assign ain[gi][gj] = bus.a_out[gi*DW +: DW];
            end else begin : g_wi
                assign ain[gi][gj] = pa[gi][gj-1];
            end
            if (gi == 0) begin : g_n
                assign bin[gi][gj] = bus.b_out[gj*DW +: DW];
            end else begin : g_ni
                assign bin[gi][gj] = pb[gi-1][gj];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else if (arr_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
                end
        end
    end

    function automatic logic [N*DW-1:0] exp_a(input int k);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (k - i >= 0 && k - i < N) r[i*DW +: DW] = ma[i][k-i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int k);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            if (k - j >= 0 && k - j < N) r[j*DW +: DW] = mb[k-j][j];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr_elem(input logic sel, input int r, input int c, input logic [DW-1:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 2'(c);
        bus.wr_data = v;
        if (sel) mb[r][c] = v; else ma[r][c] = v;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Start a run (optionally with a same-cycle write to A[0][0]) and check
    // every frame, the done pulse and the return to idle.
    task automatic run_stream(input string tag, input bit same_wr,
                              input logic [DW-1:0] same_val, input bit disturb);
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_row  = '0;
            bus.wr_col  = '0;
            bus.wr_data = same_val;
            ma[0][0]    = same_val;
        end
        bus.start = 1'b1;
        for (int k = 0; k < NT; k++) begin
            q_a.push_back(exp_a(k));
            q_b.push_back(exp_b(k));
        end
        @(posedge clk);
        for (int k = 0; k < NT; k++) begin
            logic [N*DW-1:0] ea, eb;
            @(negedge clk);
            idle_bus();
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            chk($sformatf("%s a_out t=%0d", tag, k), 64'(bus.a_out), 64'(ea));
            chk($sformatf("%s b_out t=%0d", tag, k), 64'(bus.b_out), 64'(eb));
            chk($sformatf("%s valid t=%0d", tag, k), 64'(bus.valid_out), 64'(1));
            chk($sformatf("%s busy t=%0d", tag, k), 64'(bus.busy), 64'(1));
            chk($sformatf("%s done t=%0d", tag, k), 64'(bus.done), 64'(0));
            obs_a[k] = bus.a_out;
            obs_b[k] = bus.b_out;
            if (disturb && k == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = '0;
                bus.wr_col  = '0;
                bus.wr_data = 8'd99;
                bus.start   = 1'b1;
            end
        end
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(bus.done), 64'(1));
        chk({tag, " done busy"}, 64'(bus.busy), 64'(1));
        chk({tag, " done valid"}, 64'(bus.valid_out), 64'(0));
        chk({tag, " done a_out"}, 64'(bus.a_out), 64'(0));
        chk({tag, " done b_out"}, 64'(bus.b_out), 64'(0));
        @(negedge clk);
        chk({tag, " idle done"}, 64'(bus.done), 64'(0));
        chk({tag, " idle busy"}, 64'(bus.busy), 64'(0));
        chk({tag, " idle valid"}, 64'(bus.valid_out), 64'(0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        arr_clr     = 1'b0;
        idle_bus();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset a_out", 64'(bus.a_out), 64'(0));
        chk("reset b_out", 64'(bus.b_out), 64'(0));
        chk("reset valid", 64'(bus.valid_out), 64'(0));
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Skew: A[r][c] = 4r+c+1, B = identity.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr_elem(1'b0, r, c, 8'(4 * r + c + 1));
                wr_elem(1'b1, r, c, (r == c) ? 8'd1 : 8'd0);
            end
        run_stream("skew", 1'b0, 8'd0, 1'b0);
        chk("skew a t=0", 64'(obs_a[0]), 64'h0000_0001);
        chk("skew a t=3", 64'(obs_a[3]), 64'h0D0A_0704);
        chk("skew a t=6", 64'(obs_a[6]), 64'h1000_0000);
        chk("skew b t=2", 64'(obs_b[2]), 64'h0000_0100);
        chk("skew b t=3", 64'(obs_b[3]), 64'h0000_0000);
        chk("skew b t=6", 64'(obs_b[6]), 64'h0100_0000);

        // Writes and start during a stream must be ignored.
        run_stream("ignore", 1'b0, 8'd0, 1'b1);
        run_stream("rerun", 1'b0, 8'd0, 1'b0);
        chk("rerun a t=0", 64'(obs_a[0]), 64'h0000_0001);

        // Write and start in the same idle cycle.
        run_stream("samecyc", 1'b1, 8'd42, 1'b0);
        chk("samecyc a t=0", 64'(obs_a[0]), 64'h0000_002A);

        // Reset in the middle of a stream.
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset a_out", 64'(bus.a_out), 64'(0));
        chk("midreset b_out", 64'(bus.b_out), 64'(0));
        chk("midreset valid", 64'(bus.valid_out), 64'(0));
        chk("midreset busy", 64'(bus.busy), 64'(0));
        chk("midreset done", 64'(bus.done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        @(negedge clk);
        run_stream("cleared", 1'b0, 8'd0, 1'b0);

        // End to end through the array model: all-2 times all-3 gives 24.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr_elem(1'b0, r, c, 8'd2);
                wr_elem(1'b1, r, c, 8'd3);
            end
        arr_clr = 1'b1;
        @(negedge clk);
        arr_clr = 1'b0;
        run_stream("e2e", 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("e2e out_c[%0d][%0d]", i, j), 64'(acc[i][j]), 64'd24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
